pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised next-PC generator for the fetch stage; successor of the single-width PC register.
//  Adds a valid/ready handshake to instruction memory, stall, a buffered redirect and target alignment.
//  Also adds bad-select detection and optional performance counters.
//  Sits between execute (branch decision, ALU result) and the instruction-memory fetch port.
// PARAMETERS
//  XLEN        32        address width in bits
//  RESET_VEC   'h1000    pc_out value after reset; matches the spike boot address
//  STEP        4         sequential increment in bytes
//  ALIGN_BITS  2         low target bits forced to zero; misalign flags any nonzero bit among them
//  CNT_W       32        perf counter width; used only with PC_PERF_EN
// PORTS
//  clk           in   1         clock; all logic on rising edge
//  rst           in   1         synchronous, active-low reset
//  br_valid      in   1         execute decision valid; pc_src/tar_addr/alu_res/alu_zero sampled only when 1
//  pc_src        in   3         000 seq, 001 taken if alu_zero, 010 taken if !alu_zero, 011 tar_addr, 100 alu_res
//  tar_addr      in   XLEN      branch/jump target
//  alu_res       in   XLEN      register-indirect target
//  alu_zero      in   1         ALU zero flag
//  stall         in   1         pipeline hold; blocks the PC from advancing
//  fetch_ready   in   1         imem accepts pc_out this cycle
//  pc_out        out  XLEN      fetch address
//  pc_valid      out  1         pc_out valid to imem
//  redirect      out  1         1-cycle pulse when a non-sequential target is loaded into pc_out (flush younger stages)
//  misalign      out  1         1-cycle pulse, same cycle as the redirect, when the raw target had nonzero ALIGN_BITS
//  bad_src       out  1         1-cycle pulse when br_valid && pc_src in 101..111
//  fetch_cnt     out  CNT_W     accepted fetches (PC_PERF_EN only, else tied 0)
//  redir_cnt     out  CNT_W     redirects applied (PC_PERF_EN only, else tied 0)
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - pc_out=RESET_VEC; pc_valid=0; redirect=misalign=bad_src=0; pend=0; counters=0; state=BOOT.
//   - Reset mid-operation discards any pending target.
//  Taken decision:
//   - taken = br_valid && (src==011 || src==100 || (src==001&&alu_zero) || (src==010&&!alu_zero)).
//   - tgt = (src==100 ? alu_res : tar_addr) with low ALIGN_BITS cleared.
//  accept = pc_valid && fetch_ready && !stall.
//  FSM:
//   - BOOT: pc_valid=0 for exactly one cycle after reset release -> RUN.
//   - RUN: pc_valid=1.
//     - taken && accept: pc_out<=tgt next cycle; redirect pulses that cycle.
//     - taken && !accept: pc_out stays stable (handshake: a presented address never changes before acceptance); pend<=tgt, state -> HOLD.
//     - !taken && accept: pc_out<=pc_out+STEP (wraps modulo 2^XLEN).
//     - otherwise: hold.
//   - HOLD: pc_out stable.
//     - Further taken decisions are ignored (wrong-path).
//     - On accept: pc_out<=pend, redirect pulses, state -> RUN.
//  Latency: decision to new pc_out is 1 cycle if accepted, else 1 cycle after the accept.
//  Invalid pc_src: bad_src pulses; treated as not taken, no redirect.
//  Simultaneous stall && fetch_ready: no accept; stall wins.
// CONFIGURATION
//  PC_PERF_EN defined:
//   - fetch_cnt increments on each accept; redir_cnt increments on each redirect pulse.
//   - Both saturate at all-ones, never wrap; cleared by reset.
//  PC_PERF_EN undefined: no counter flops; both outputs constant 0.
// STRUCTURE
//  pc_pkg: pc_src encodings (PC_SEQ, PC_BEQ, PC_BNE, PC_JMP, PC_JALR), FSM state enum {BOOT,RUN,HOLD}.
//  Sub-module pc_perf_ctr: one saturating CNT_W counter with inc/clear; instantiated twice under PC_PERF_EN.
// TESTING
//  Reset, then fetch_ready=1 steady:
//   - BOOT cycle: pc_valid=0, pc_out=0x1000.
//   - Then pc_out 0x1000, 0x1004, 0x1008 on consecutive cycles.
//  At pc_out=0x1008: br_valid=1, src=001, alu_zero=1, tar_addr=0x2000, fetch_ready=1:
//   - next cycle pc_out=0x2000, redirect=1 for 1 cycle.
//  fetch_ready=0 at pc_out=0x2000; src=100, alu_res=0x3003:
//   - pc_out stays 0x2000 and state=HOLD.
//   - A second jump to 0x4000 is ignored.
//   - fetch_ready=1 -> pc_out=0x3000, redirect=1 and misalign=1 in the same cycle.
//  stall=1 with fetch_ready=1 for 3 cycles: pc_out unchanged. src=101 with br_valid=1: bad_src=1, pc advances by 4.
//  Reset asserted while in HOLD: next cycle pc_out=0x1000, pc_valid=0, pending target lost.
//  PC_PERF_EN, CNT_W=4: 20 accepts -> fetch_cnt saturates at 15. Undefined: fetch_cnt stays 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage next-PC generator: branch-select codes and FSM states.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'b000,
        PC_BEQ  = 3'b001,
        PC_BNE  = 3'b010,
        PC_JMP  = 3'b011,
        PC_JALR = 3'b100
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_perf_ctr.sv
// Saturating event counter with synchronous active-low reset and a synchronous clear.
module pc_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator with imem valid/ready handshake, stall, buffered redirect and target alignment.
// Optional performance counters are built when PC_PERF_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h0000_1000),
    parameter int              STEP       = 4,
    parameter int              ALIGN_BITS = 2,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [2:0]       pc_src,
    input  logic [XLEN-1:0]  tar_addr,
    input  logic [XLEN-1:0]  alu_res,
    input  logic             alu_zero,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             redirect,
    output logic             misalign,
    output logic             bad_src,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic            taken_s;
    logic            bad_s;
    logic            accept_s;
    logic            raw_mis_s;
    logic [XLEN-1:0] raw_tgt_s;
    logic [XLEN-1:0] tgt_s;

    pc_state_e       state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pend_r;
    logic            pend_mis_r;
    logic            pc_valid_r;
    logic            redirect_r;
    logic            misalign_r;
    logic            bad_src_r;

    // Decode the execute-stage decision into taken / target / bad-select.
    always_comb begin
        taken_s   = 1'b0;
        bad_s     = 1'b0;
        raw_tgt_s = tar_addr;
        if (br_valid) begin
            case (pc_src)
                PC_SEQ:  taken_s = 1'b0;
                PC_BEQ:  taken_s = alu_zero;
                PC_BNE:  taken_s = !alu_zero;
                PC_JMP:  taken_s = 1'b1;
                PC_JALR: begin
                    taken_s   = 1'b1;
                    raw_tgt_s = alu_res;
                end
                default: bad_s = 1'b1;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

    assign tgt_s     = raw_tgt_s & ~ALIGN_MASK;
    assign raw_mis_s = |(raw_tgt_s & ALIGN_MASK);
    // Stall overrides a ready imem: nothing is accepted while the pipe holds.
    assign accept_s  = pc_valid_r && fetch_ready && !stall;

    // Fetch FSM: a presented address never changes until imem accepts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= BOOT;
            pc_r       <= RESET_VEC;
            pend_r     <= {XLEN{1'b0}};
            pend_mis_r <= 1'b0;
            pc_valid_r <= 1'b0;
            redirect_r <= 1'b0;
            misalign_r <= 1'b0;
            bad_src_r  <= 1'b0;
        end else begin
            redirect_r <= 1'b0;
            misalign_r <= 1'b0;
            bad_src_r  <= bad_s;
            case (state_r)
                BOOT: begin
                    pc_valid_r <= 1'b1;
                    state_r    <= RUN;
                end
                RUN: begin
                    if (taken_s && accept_s) begin
                        pc_r       <= tgt_s;
                        redirect_r <= 1'b1;
                        misalign_r <= raw_mis_s;
                    end else if (taken_s) begin
                        pend_r     <= tgt_s;
                        pend_mis_r <= raw_mis_s;
                        state_r    <= HOLD;
                    end else if (accept_s) begin
                        pc_r <= pc_r + XLEN'(STEP);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                HOLD: begin
                    // Younger decisions seen here are wrong-path and dropped.
                    if (accept_s) begin
                        pc_r       <= pend_r;
                        redirect_r <= 1'b1;
                        misalign_r <= pend_mis_r;
                        state_r    <= RUN;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    pc_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out   = pc_r;
    assign pc_valid = pc_valid_r;
    assign redirect = redirect_r;
    assign misalign = misalign_r;
    assign bad_src  = bad_src_r;

`ifdef PC_PERF_EN
    pc_perf_ctr #(.CNT_W(CNT_W)) u_fetch_ctr (
        .clk (clk),
        .rst (rst),
        .inc (accept_s),
        .clr (1'b0),
        .cnt (fetch_cnt)
    );

    pc_perf_ctr #(.CNT_W(CNT_W)) u_redir_ctr (
        .clk (clk),
        .rst (rst),
        .inc (redirect_r),
        .clr (1'b0),
        .cnt (redir_cnt)
    );
`else
    assign fetch_cnt = {CNT_W{1'b0}};
    assign redir_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expectations are hand-computed per step.
// Counter expectations follow PC_PERF_EN when it is defined for the build.
module tb_pc_gen;
    import pc_pkg::*;

`ifdef PC_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  pc_src;
    logic [31:0] tar_addr;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        stall;
    logic        fetch_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        redirect;
    logic        misalign;
    logic        bad_src;
    logic [3:0]  fetch_cnt;
    logic [3:0]  redir_cnt;

    int checks   = 0;
    int failures = 0;

    pc_gen #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .pc_src      (pc_src),
        .tar_addr    (tar_addr),
        .alu_res     (alu_res),
        .alu_zero    (alu_zero),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .pc_out      (pc_out),
        .pc_valid    (pc_valid),
        .redirect    (redirect),
        .misalign    (misalign),
        .bad_src     (bad_src),
        .fetch_cnt   (fetch_cnt),
        .redir_cnt   (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; br_valid = 1'b0; pc_src = 3'b000; tar_addr = 32'h0;
        alu_res = 32'h0; alu_zero = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        step();
        step();
        check("rst_pc", pc_out, 32'h1000);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_bad_src", {31'b0, bad_src}, 32'd0);
        check("rst_fetch_cnt", {28'b0, fetch_cnt}, 32'd0);

        // Reset released: this cycle is BOOT, nothing presented yet.
        rst = 1'b1;
        #1;
        check("boot_valid", {31'b0, pc_valid}, 32'd0);
        check("boot_pc", pc_out, 32'h1000);
        step();
        check("run_valid", {31'b0, pc_valid}, 32'd1);
        check("seq0", pc_out, 32'h1000);
        step();
        check("seq1", pc_out, 32'h1004);
        step();
        check("seq2", pc_out, 32'h1008);

        // Taken BEQ accepted immediately.
        br_valid = 1'b1; pc_src = 3'b001; alu_zero = 1'b1; tar_addr = 32'h2000;
        step();
        check("beq_pc", pc_out, 32'h2000);
        check("beq_redirect", {31'b0, redirect}, 32'd1);
        check("beq_misalign", {31'b0, misalign}, 32'd0);

        // JALR while imem is not ready: target buffered, misaligned raw target.
        pc_src = 3'b100; alu_res = 32'h3003; fetch_ready = 1'b0;
        step();
        check("hold_pc", pc_out, 32'h2000);
        check("hold_redirect", {31'b0, redirect}, 32'd0);
        check("hold_state", {30'b0, dut.state_r}, {30'b0, HOLD});

        // Wrong-path jump while holding is dropped.
        pc_src = 3'b011; tar_addr = 32'h4000;
        step();
        check("hold2_pc", pc_out, 32'h2000);
        check("hold2_redirect", {31'b0, redirect}, 32'd0);

        br_valid = 1'b0; fetch_ready = 1'b1;
        step();
        check("pend_pc", pc_out, 32'h3000);
        check("pend_redirect", {31'b0, redirect}, 32'd1);
        check("pend_misalign", {31'b0, misalign}, 32'd1);

        // Stall wins over fetch_ready.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc_out, 32'h3000);
            check("stall_redirect", {31'b0, redirect}, 32'd0);
        end
        stall = 1'b0;

        // Invalid select: flagged, treated as sequential.
        br_valid = 1'b1; pc_src = 3'b101; tar_addr = 32'h7000;
        step();
        check("bad_flag", {31'b0, bad_src}, 32'd1);
        check("bad_pc", pc_out, 32'h3004);
        check("bad_redirect", {31'b0, redirect}, 32'd0);
        br_valid = 1'b0;
        step();
        check("bad_clear", {31'b0, bad_src}, 32'd0);
        check("seq3", pc_out, 32'h3008);
        check("mid_fetch_cnt", {28'b0, fetch_cnt}, PERF_ON ? 32'd6 : 32'd0);
        check("mid_redir_cnt", {28'b0, redir_cnt}, PERF_ON ? 32'd2 : 32'd0);

        // Reset while in HOLD drops the buffered target.
        fetch_ready = 1'b0; br_valid = 1'b1; pc_src = 3'b011; tar_addr = 32'h5000;
        step();
        check("hold3_state", {30'b0, dut.state_r}, {30'b0, HOLD});
        rst = 1'b0; br_valid = 1'b0;
        step();
        check("rst2_pc", pc_out, 32'h1000);
        check("rst2_valid", {31'b0, pc_valid}, 32'd0);
        check("rst2_redir_cnt", {28'b0, redir_cnt}, 32'd0);
        rst = 1'b1; fetch_ready = 1'b1;
        step();
        check("rst2_run_pc", pc_out, 32'h1000);
        check("rst2_run_valid", {31'b0, pc_valid}, 32'd1);
        step();
        check("rst2_seq_pc", pc_out, 32'h1004);
        check("rst2_no_redirect", {31'b0, redirect}, 32'd0);

        // 21 accepts since reset: fetch counter pins at 15.
        for (int i = 0; i < 20; i++) step();
        check("long_pc", pc_out, 32'h1054);
        check("sat_fetch_cnt", {28'b0, fetch_cnt}, PERF_ON ? 32'd15 : 32'd0);
        check("sat_redir_cnt", {28'b0, redir_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
